// File: rtl/seg_scan_driver_if.sv
// Signal bundle between a frame source and seg_scan_driver: frame load inputs
// and the segment/anode pin outputs.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] iData;
    logic [NUM_DIGITS-1:0]   iBlank;
    logic [NUM_DIGITS-1:0]   iDp;
    logic                    iLoad;
    logic [6:0]              oSeg;
    logic                    oDp;
    logic [NUM_DIGITS-1:0]   oAn;
    logic                    oFrame;

    modport master (
        output iData, iBlank, iDp, iLoad,
        input  oSeg, oDp, oAn, oFrame
    );

    modport slave (
        input  iData, iBlank, iDp, iLoad,
        output oSeg, oDp, oAn, oFrame
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered frame,
// programmable slot length, dead time, BCD/hex decode and leading-zero suppression.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV    = 100000,
    parameter int DEAD_CYCLES = 2,
    parameter int HEX_MODE    = 0,
    parameter int LZS         = 0
) (
    input logic         clk,
    input logic         rst,
    seg_scan_driver_if.slave bus
);
    localparam int PC_W  = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0]  PC_DEAD  = PC_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   dp;
    } frame_t;

    logic [PC_W-1:0]       pc_q, pc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    frame_t                stg_q, stg_d, shd_q, shd_d;
    logic                  pend_q, pend_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dpo_q, dpo_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  boundary;
    logic [NUM_DIGITS-1:0] blank_v;
    logic                  lead;
    logic                  hard;
    logic [3:0]            v;
    logic [3:0]            cur_val;

    // Raw glyph for every nibble; BCD-mode blanking of 10..15 is applied separately.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        pc_d    = pc_q;
        idx_d   = idx_q;
        stg_d   = stg_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        blank_v = '0;
        lead    = 1'b1;
        hard    = 1'b0;
        v       = 4'd0;

        boundary = (idx_q == IDX_LAST) && (pc_q == PC_LAST);

        if (pc_q == PC_LAST) begin
            pc_d  = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            pc_d  = pc_q + 1'b1;
        end

        // Shadow takes the old staging value; a load in the same cycle stays pending.
        if (boundary && pend_q) begin
            shd_d  = stg_q;
            pend_d = 1'b0;
        end
        if (bus.iLoad) begin
            stg_d  = '{data: bus.iData, blank: bus.iBlank, dp: bus.iDp};
            pend_d = 1'b1;
        end

        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v          = shd_q.data[4*k +: 4];
            hard       = shd_q.blank[k] || (HEX_MODE == 0 && v > 4'd9);
            blank_v[k] = hard || (LZS != 0 && k != 0 && lead && v == 4'd0);
            lead       = lead && (v == 4'd0 || hard);
        end

        cur_val = shd_q.data[4*idx_q +: 4];
        seg_d   = blank_v[idx_q] ? 7'b1111111 : glyph(cur_val);
        dpo_d   = ~shd_q.dp[idx_q];
        an_d    = '1;
        if (pc_q >= PC_DEAD) begin
            an_d[idx_q] = 1'b0;
        end
        frame_d = boundary && pend_q;
    end

    // NOTE: sequential state uses non-blocking assignments; the comb block above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: frame registers are reset too, so the display shows zeros after reset.
            pc_q    <= '0;
            idx_q   <= '0;
            stg_q   <= '0;
            shd_q   <= '0;
            pend_q  <= 1'b0;
            seg_q   <= 7'b1111111;
            dpo_q   <= 1'b1;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            seg_q   <= seg_d;
            dpo_q   <= dpo_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign bus.oSeg   = seg_q;
    assign bus.oDp    = dpo_q;
    assign bus.oAn    = an_q;
    assign bus.oFrame = frame_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: four seg_scan_driver instances (BCD/hex x LZS off/on) share
// one stimulus stream and are compared each cycle against a cycle-count reference model.
module tb_seg_scan_driver;
    localparam int ND   = 4;
    localparam int SD   = 4;
    localparam int DC   = 1;
    localparam int NCFG = 4;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4*ND-1:0] data;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   dp;
    logic            load;

    logic [6:0]    seg_o   [NCFG];
    logic          dp_o    [NCFG];
    logic [ND-1:0] an_o    [NCFG];
    logic          frame_o [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();
        assign bus.iData  = data;
        assign bus.iBlank = blank;
        assign bus.iDp    = dp;
        assign bus.iLoad  = load;
        seg_scan_driver #(
            .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC),
            .HEX_MODE(g % 2), .LZS(g / 2)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
        assign seg_o[g]   = bus.oSeg;
        assign dp_o[g]    = bus.oDp;
        assign an_o[g]    = bus.oAn;
        assign frame_o[g] = bus.oFrame;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: scan position derived from cycles since reset release.
    int       t;
    bit       m_pend;
    bit [3:0] stg_v [ND];
    bit       stg_b [ND];
    bit       stg_p [ND];
    bit [3:0] shd_v [ND];
    bit       shd_b [ND];
    bit       shd_p [ND];

    function automatic bit is_hard(int hex, int k);
        return shd_b[k] || (hex == 0 && shd_v[k] > 9);
    endfunction

    function automatic logic [6:0] exp_seg(int hex, int lzs, int k);
        bit blanked = is_hard(hex, k);
        bit above_clear = 1'b1;
        if (lzs != 0 && k > 0 && shd_v[k] == 0) begin
            for (int j = k + 1; j < ND; j++)
                if (!(shd_v[j] == 0 || is_hard(hex, j))) above_clear = 1'b0;
            if (above_clear) blanked = 1'b1;
        end
        return blanked ? 7'b1111111 : SEG_TBL[shd_v[k]];
    endfunction

    function automatic bit at_boundary();
        return !rst && (t % SD == SD - 1) && ((t / SD) % ND == ND - 1);
    endfunction

    task automatic step();
        logic [6:0]    e_seg [NCFG];
        logic          e_dp;
        logic [ND-1:0] e_an;
        logic          e_frame;
        int            pc;
        int            idx;
        bit            bnd;
        bnd = 1'b0;
        if (rst) begin
            e_an    = '1;
            e_dp    = 1'b1;
            e_frame = 1'b0;
            for (int g = 0; g < NCFG; g++) e_seg[g] = 7'b1111111;
        end else begin
            pc  = t % SD;
            idx = (t / SD) % ND;
            bnd = (pc == SD - 1) && (idx == ND - 1);
            e_an = '1;
            if (pc >= DC) e_an[idx] = 1'b0;
            e_dp    = !shd_p[idx];
            e_frame = bnd && m_pend;
            for (int g = 0; g < NCFG; g++) e_seg[g] = exp_seg(g % 2, g / 2, idx);
        end

        @(posedge clk);
        if (rst) begin
            t = 0;
            m_pend = 1'b0;
            for (int k = 0; k < ND; k++) begin
                stg_v[k] = 0; stg_b[k] = 0; stg_p[k] = 0;
                shd_v[k] = 0; shd_b[k] = 0; shd_p[k] = 0;
            end
        end else begin
            if (bnd && m_pend) begin
                shd_v = stg_v; shd_b = stg_b; shd_p = stg_p;
                m_pend = 1'b0;
            end
            if (load) begin
                for (int k = 0; k < ND; k++) begin
                    stg_v[k] = data[4*k +: 4];
                    stg_b[k] = blank[k];
                    stg_p[k] = dp[k];
                end
                m_pend = 1'b1;
            end
            t++;
        end

        #1;
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("seg[c%0d]", g), 32'(seg_o[g]), 32'(e_seg[g]));
            check($sformatf("dp[c%0d]", g), 32'(dp_o[g]), 32'(e_dp));
            check($sformatf("an[c%0d]", g), 32'(an_o[g]), 32'(e_an));
            check($sformatf("frame[c%0d]", g), 32'(frame_o[g]), 32'(e_frame));
        end
    endtask

    task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] b, input logic [ND-1:0] p);
        data  = d;
        blank = b;
        dp    = p;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic goto_boundary();
        for (int i = 0; i < ND * SD && !at_boundary(); i++) step();
    endtask

    function automatic logic [3:0] rnd_nib();
        return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        data  = '0;
        blank = '0;
        dp    = '0;
        load  = 1'b0;
        rst   = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Free scan of the reset frame.
        repeat (2 * ND * SD) step();

        // Mid-frame load appears only after the frame boundary.
        repeat (5) step();
        do_load(16'h1234, 4'b0000, 4'b0000);
        repeat (2 * ND * SD) step();

        // Load landing exactly in the boundary cycle waits one more frame.
        goto_boundary();
        do_load(16'h5555, 4'b0000, 4'b0000);
        repeat (2 * ND * SD + 3) step();

        // Digit values above 9, leading zeros, all-zero frame.
        do_load(16'h0B0B, 4'b0000, 4'b0000);
        repeat (2 * ND * SD) step();
        do_load(16'h0050, 4'b0000, 4'b0000);
        repeat (2 * ND * SD) step();
        do_load(16'h0000, 4'b0000, 4'b0000);
        repeat (2 * ND * SD) step();

        // Forced blank plus decimal point on digit 1.
        do_load(16'h4321, 4'b0010, 4'b0010);
        repeat (2 * ND * SD) step();

        // Reset mid-slot with a load still pending.
        repeat (3) step();
        do_load(16'h9876, 4'b0000, 4'b1111);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2 * ND * SD) step();

        // Randomized loads, occasional boundary-cycle loads and resets.
        repeat (200) begin
            logic [4*ND-1:0] d;
            repeat ($urandom_range(0, 20)) step();
            for (int k = 0; k < ND; k++) d[4*k +: 4] = rnd_nib();
            if ($urandom_range(0, 9) == 0) goto_boundary();
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            do_load(d, ($urandom_range(0, 3) == 0) ? ND'($urandom) : '0, ND'($urandom));
        end
        repeat (2 * ND * SD) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
